serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = a - b - borrow_in, LSB first, one bit per clock through a 1-bit full-subtract cell and a registered borrow.
- Inverse-direction companion to the 1-bit full adder.
- Sits beside the adder datapath where area matters more than latency.
- Start/busy/done handshake; result is held until the next accepted start.

Parameters:
NUM_BITS, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on the rising edge while not busy
a  input  NUM_BITS  minuend, latched on the accepted start
b  input  NUM_BITS  subtrahend, latched on the accepted start
borrow_in  input  1  initial borrow, latched on the accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result becomes valid
diff  output  NUM_BITS  result register, a - b - borrow_in modulo 2^NUM_BITS
borrow_out  output  1  final borrow; 1 when a < b + borrow_in (unsigned)

Behaviour:
- Reset: rst high forces the state machine to IDLE immediately, regardless of clk.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. If start=1 at the edge, latch a, b, borrow_in and clear the bit counter, then go to RUN.
  - RUN: busy=1, done=0. Each edge processes bit i = counter.
    - d = a_sh[0] ^ b_sh[0] ^ br
    - br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
    - a_sh and b_sh shift right by one; d shifts into the MSB of the internal result shift register; counter increments.
    - On the edge that processes bit NUM_BITS-1: copy the result shift register to diff, copy br_next to borrow_out, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 at this edge is accepted exactly as in IDLE (back-to-back operation) and goes to RUN.
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0, bits processed at edges E1..E_NUM_BITS. done is high in the cycle following E_NUM_BITS.
  - Start-to-start throughput is NUM_BITS+1 cycles.
- start while busy=1 is ignored. The operand inputs are don't-care outside the accepting edge.
- diff and borrow_out change only at the completion edge or on reset. They hold the previous result throughout a new RUN, and partial results are never visible.
- Arithmetic is unsigned modulo 2^NUM_BITS. borrow_out=1 exactly when a < b + borrow_in.
  - Example: a=0, b=0, borrow_in=1 gives diff=all ones, borrow_out=1.
- rst asserted mid-RUN aborts the operation. The prior diff is lost (cleared to 0) and no done pulse is produced.
- Immediate assertions flag an error when start is X/Z, and when a, b or borrow_in is X/Z at the accepting edge.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN
- Defined:
  - Adds output port overflow (output, 1 bit): two's-complement signed overflow of the operation.
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the latched operands.
  - Updated at the same completion edge as diff; reset value 0; held like diff.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- NUM_BITS=8, start with a=0x5A, b=0x23, borrow_in=0: busy high for 8 cycles, done pulses in cycle 9 after E0, diff=0x37, borrow_out=0.
- a=0x00, b=0x01, borrow_in=0: diff=0xFF, borrow_out=1. Then a=0x10, b=0x10, borrow_in=1: diff=0xFF, borrow_out=1.
- Handshake:
  - Pulse start again at bits 2 and 5 of an active RUN: both ignored, operands unchanged, single done pulse.
  - Assert start during the done cycle: a new RUN begins immediately, busy=1 on the next cycle, and the first result holds until the second completes.
- Reset mid-op: start a=0xF0, b=0x0F, assert rst asynchronously mid-cycle after bit 3. All outputs are 0 immediately, no done pulse, state is IDLE. A new start after release completes normally with diff=0xE1.
- SERIAL_SUB_OVF_EN defined:
  - a=0x80, b=0x01: diff=0x7F, overflow=1, borrow_out=0.
  - a=0x7F, b=0xFF: diff=0x80, overflow=1, borrow_out=1.
  - a=0x05, b=0x03: diff=0x02, overflow=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - borrow_in with start/busy/done handshake; define SERIAL_SUB_OVF_EN to add the signed overflow output
module serial_subtractor #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic                overflow
`endif
);
  localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [NUM_BITS-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0] cnt;
  logic br, br_nx, d, last, accept;
  // state register; reset drops straight back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // full-subtract cell, handshake outputs and next state
  always_comb begin
    busy     = state == RUN;
    done     = state == DONE;
    accept   = start && state != RUN;
    last     = state == RUN && cnt == CW'(NUM_BITS - 1);
    d        = a_sh[0] ^ b_sh[0] ^ br;
    br_nx    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  // operand shifting, borrow chain and result capture at the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      overflow   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      br   <= borrow_in;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {d, res_sh[NUM_BITS-1:1]};
      br     <= br_nx;
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff       <= {d, res_sh[NUM_BITS-1:1]};
        borrow_out <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
        overflow   <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
`endif
      end
    end
  end
  // unknown handshake or operand values are flagged at the sampling edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(start)) else $error("serial_subtractor: start is X/Z");
      if (accept) assert (!$isunknown({a, b, borrow_in})) else $error("serial_subtractor: operand X/Z on accepted start");
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor with NUM_BITS=8
module tb_serial_subtractor;
  logic clk, rst, start, borrow_in, busy, done, borrow_out;
  logic [7:0] a, b, diff;
`ifdef SERIAL_SUB_OVF_EN
  logic overflow;
`endif
  typedef struct {logic [7:0] d; logic bo; logic ov;} exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;

  serial_subtractor #(.NUM_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    , .overflow(overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    logic [8:0] r;
    exp_t e;
    a = ia; b = ib; borrow_in = ibin; start = 1'b1;
    r = {1'b0, ia} - {1'b0, ib} - {8'd0, ibin};
    e.d = r[7:0];
    e.bo = r[8];
    e.ov = (ia[7] != ib[7]) && (r[7] != ia[7]);
    q.push_back(e);
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) nb++;
    end while (!done && n < 100);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff: got %h expected 00", diff); end
    checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL reset_borrow: got %b expected 0", borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_basic;
    logic [7:0] ta[10], tb_v[10];
    logic tc[10];
    int n, nb;
    exp_t e;
    ta[0] = 8'h5A; tb_v[0] = 8'h23; tc[0] = 1'b0;
    ta[1] = 8'h00; tb_v[1] = 8'h01; tc[1] = 1'b0;
    ta[2] = 8'h10; tb_v[2] = 8'h10; tc[2] = 1'b1;
    ta[3] = 8'h00; tb_v[3] = 8'h00; tc[3] = 1'b1;
    for (int i = 4; i < 10; i++) begin
      ta[i] = 8'($urandom_range(0, 255));
      tb_v[i] = 8'($urandom_range(0, 255));
      tc[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      launch(ta[i], tb_v[i], tc[i]);
      wait_done(n, nb);
      e = q.pop_front();
      checks++; if (n !== 9) begin failures++; $display("FAIL op%0d_latency: got %0d expected 9", i, n); end
      checks++; if (nb !== 8) begin failures++; $display("FAIL op%0d_busy_cycles: got %0d expected 8", i, nb); end
      checks++; if (diff !== e.d) begin failures++; $display("FAIL op%0d_diff: got %h expected %h", i, diff, e.d); end
      checks++; if (borrow_out !== e.bo) begin failures++; $display("FAIL op%0d_borrow: got %b expected %b", i, borrow_out, e.bo); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (overflow !== e.ov) begin failures++; $display("FAIL op%0d_ovf: got %b expected %b", i, overflow, e.ov); end
`endif
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL op%0d_done_width: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_ignore_start;
    int ndone, kdone;
    exp_t e;
    ndone = 0; kdone = 0;
    @(negedge clk);
    launch(8'hC3, 8'h3C, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 5);
      if (start) begin a = 8'hFF; b = 8'hFF; borrow_in = 1'b1; end
      if (done) begin ndone++; kdone = k; end
    end
    e = q.pop_front();
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    checks++; if (kdone !== 9) begin failures++; $display("FAIL ignore_done_cycle: got %0d expected 9", kdone); end
    checks++; if (diff !== e.d || borrow_out !== e.bo) begin failures++; $display("FAIL ignore_result: got %h/%b expected %h/%b", diff, borrow_out, e.d, e.bo); end
  endtask

  task automatic test_back_to_back;
    int n, nb;
    logic b1, hold_ok;
    exp_t e1, e2;
    @(negedge clk);
    launch(8'h5A, 8'h23, 1'b0);
    wait_done(n, nb);
    e1 = q.pop_front();
    checks++; if (diff !== e1.d || done !== 1'b1) begin failures++; $display("FAIL b2b_first: got %h done=%b expected %h done=1", diff, done, e1.d); end
    launch(8'h89, 8'h77, 1'b0);
    n = 0; hold_ok = 1'b1; b1 = 1'b0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) b1 = busy;
      if (!done && diff !== e1.d) hold_ok = 1'b0;
    end while (!done && n < 100);
    e2 = q.pop_front();
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL b2b_busy_next: got %b expected 1", b1); end
    checks++; if (n !== 9) begin failures++; $display("FAIL b2b_latency: got %0d expected 9", n); end
    checks++; if (hold_ok !== 1'b1) begin failures++; $display("FAIL b2b_hold: got %b expected 1", hold_ok); end
    checks++; if (diff !== e2.d || borrow_out !== e2.bo) begin failures++; $display("FAIL b2b_second: got %h/%b expected %h/%b", diff, borrow_out, e2.d, e2.bo); end
  endtask

  task automatic test_reset_mid;
    int n, nb, ndone;
    exp_t e;
    ndone = 0;
    @(negedge clk);
    launch(8'hF0, 8'h0F, 1'b0);
    repeat (3) begin @(negedge clk); start = 1'b0; end
    #2 rst = 1'b1;
    #1;
    void'(q.pop_back());
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_flags: busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (diff !== 8'h00 || borrow_out !== 1'b0) begin failures++; $display("FAIL abort_result: got %h/%b expected 00/0", diff, borrow_out); end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin @(negedge clk); if (done || busy) ndone++; end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL abort_no_done: got %0d active cycles expected 0", ndone); end
    @(negedge clk);
    launch(8'hF0, 8'h0F, 1'b0);
    wait_done(n, nb);
    e = q.pop_front();
    checks++; if (n !== 9 || diff !== e.d || borrow_out !== e.bo) begin failures++; $display("FAIL after_abort: n=%0d got %h/%b expected 9 %h/%b", n, diff, borrow_out, e.d, e.bo); end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_overflow;
    logic [7:0] oa[3], ob[3];
    int n, nb;
    exp_t e;
    oa[0] = 8'h80; ob[0] = 8'h01;
    oa[1] = 8'h7F; ob[1] = 8'hFF;
    oa[2] = 8'h05; ob[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      launch(oa[i], ob[i], 1'b0);
      wait_done(n, nb);
      e = q.pop_front();
      checks++; if (diff !== e.d || borrow_out !== e.bo) begin failures++; $display("FAIL ovf%0d_result: got %h/%b expected %h/%b", i, diff, borrow_out, e.d, e.bo); end
      checks++; if (overflow !== e.ov) begin failures++; $display("FAIL ovf%0d_flag: got %b expected %b", i, overflow, e.ov); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
`ifdef SERIAL_SUB_OVF_EN
    test_overflow;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
